oam_dma_arbiter: RTL and testbench
==================================

# oam_dma_arbiter

Shares the CPU's single memory port between the CPU datapath (fetch and operand accesses) and an OAM DMA engine. A CPU write to the DMA trigger address captures a source page. The block then stalls the CPU and copies 256 bytes from page·$100 to the OAM data port. It sits between the CPU memory interface and the system memory bus, with stall feeding the CPU control/PC-block logic.

## Interface
- MEM_ADDR_SIZE, 16, memory address width
- DMA_TRIG_ADDR, 16'h4014, CPU write here starts DMA
- OAM_DATA_ADDR, 16'h2004, DMA write destination
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- cpu_req_i  in  1  CPU access request
- cpu_we_i  in  1  CPU write (1) / read (0)
- cpu_addr_i  in  MEM_ADDR_SIZE  CPU address
- cpu_wdata_i  in  8  CPU write data
- cpu_gnt_o  out  1  CPU access completed this cycle
- cpu_rdata_o  out  8  CPU read data (valid with cpu_gnt_o)
- cpu_stall_o  out  1  CPU must hold state (DMA owns bus)
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_addr_o  out  MEM_ADDR_SIZE  bus address
- mem_wdata_o  out  8  bus write data
- mem_rdata_i  in  8  bus read data
- mem_valid_i  in  1  bus access completes this cycle
- dma_active_o  out  1  FSM not in IDLE

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE: bus pass-through. mem_* = cpu_* (combinational), cpu_gnt_o = cpu_req_i & mem_valid_i, cpu_rdata_o = mem_rdata_i.
- Trigger: in IDLE, cpu_req_i & cpu_we_i & cpu_addr_i==DMA_TRIG_ADDR.
  - Trigger is absorbed: mem_req_o=0, cpu_gnt_o=1 the same cycle (independent of mem_valid_i).
  - page_q <= cpu_wdata_i, cnt_q <= 0, next state HALT.
- HALT: one dummy cycle, no bus request. Next state is ALIGN if parity_q==1, else READ.
- ALIGN: one dummy cycle, no bus request, then READ.
- READ: mem_req_o=1, mem_we_o=0, mem_addr_o={page_q,cnt_q}. On mem_valid_i: data_q <= mem_rdata_i, go to WRITE. Otherwise hold.
- WRITE: mem_req_o=1, mem_we_o=1, mem_addr_o=OAM_DATA_ADDR, mem_wdata_o=data_q. On mem_valid_i: cnt_q++.
  - If cnt_q was 8'hFF, go to IDLE; otherwise go to READ.
- parity_q: 1-bit free-running toggle every clock from reset. It models the CPU cycle parity for 513/514-cycle transfers.
- Outside IDLE:
  - cpu_stall_o=1, cpu_gnt_o=0, cpu_rdata_o=0.
  - CPU requests are ignored, not queued. The CPU holds its request under stall.
- cnt_q is 8-bit. The address low byte wraps naturally; there is no page carry.
- dma_active_o = (state != IDLE). cpu_stall_o = dma_active_o.

## Timing
- Reset values: state IDLE, parity_q 0, page_q 0, cnt_q 0, data_q 0. In IDLE all outputs follow pass-through, giving 0 with idle inputs. cpu_stall_o=0, dma_active_o=0.
- Stall rises the cycle after the trigger cycle and falls the cycle after the final WRITE completes.
- With mem_valid_i tied 1, the stall length is 513 cycles (parity 0 at HALT) or 514 cycles (parity 1).
- Each mem_valid_i=0 cycle in READ/WRITE extends the stall by one cycle. Address and data are held stable while waiting.
- Reset mid-DMA returns the block to IDLE immediately and drops the stall asynchronously. The partial transfer is abandoned.
- A trigger write with mem_valid_i=0 still starts DMA; the trigger never reaches memory.
- A CPU read of DMA_TRIG_ADDR is plain pass-through.

## Structure
- Shared package: dma_state_t enum (IDLE, HALT, ALIGN, READ, WRITE), DMA_TRIG_ADDR and OAM_DATA_ADDR constants.
- Single module. The FSM, counters and output mux are kept inline; no sub-module is needed.

## Test plan
- Pass-through: CPU read $8000 with mem_rdata_i=8'hA9 and valid=1. Expect mem_addr_o=$8000, cpu_gnt_o=1, cpu_rdata_o=8'hA9, stall=0.
- DMA, even parity: write 8'h02 to $4014 with memory returning addr[7:0].
  - Expect 256 writes to $2004 with data 0..255.
  - Expect read addresses $0200..$02FF.
  - Expect stall high for exactly 513 cycles.
- DMA, odd parity: same trigger one cycle later. Expect an ALIGN cycle and a 514-cycle stall.
- Wait states: mem_valid_i=0 for 3 cycles on the 1st READ and 2 cycles on the last WRITE. Expect stall of 518 cycles and held address/data throughout.
- CPU request during DMA: cpu_req_i=1 to $8000 held. Expect cpu_gnt_o=0 until stall falls, then granted on the next cycle with valid=1.
- Reset at cnt_q=8'h40 in WRITE: expect state IDLE, stall=0, mem_req_o=0 while rstn_i is low. Expect normal pass-through after release.

Source files
------------

// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM DMA arbiter: FSM state encoding and
// the fixed addresses the arbiter decodes or drives.
package oam_dma_arbiter_pkg;

    localparam int MEM_ADDR_SIZE = 16;

    localparam logic [MEM_ADDR_SIZE-1:0] DMA_TRIG_ADDR = 16'h4014;
    localparam logic [MEM_ADDR_SIZE-1:0] OAM_DATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage : oam_dma_arbiter_pkg

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and system-bus-side signals of the arbiter in one bundle.
// The slave modport is the arbiter itself; master is the surrounding system.
interface oam_dma_arbiter_if;
    import oam_dma_arbiter_pkg::*;

    logic                     cpu_req_i;
    logic                     cpu_we_i;
    logic [MEM_ADDR_SIZE-1:0] cpu_addr_i;
    logic [7:0]               cpu_wdata_i;
    logic                     cpu_gnt_o;
    logic [7:0]               cpu_rdata_o;
    logic                     cpu_stall_o;

    logic                     mem_req_o;
    logic                     mem_we_o;
    logic [MEM_ADDR_SIZE-1:0] mem_addr_o;
    logic [7:0]               mem_wdata_o;
    logic [7:0]               mem_rdata_i;
    logic                     mem_valid_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  mem_rdata_i, mem_valid_i,
        output cpu_gnt_o, cpu_rdata_o, cpu_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output mem_rdata_i, mem_valid_i,
        input  cpu_gnt_o, cpu_rdata_o, cpu_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface : oam_dma_arbiter_if

// File: rtl/oam_dma_arbiter.sv
// Shares the CPU memory port with an OAM DMA engine: a CPU write to the
// trigger address stalls the CPU and copies one 256-byte page to OAM data.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
(
    input  logic                clk_i,
    input  logic                rstn_i,
    oam_dma_arbiter_if.slave    bus,
    output logic                dma_active_o
);

    dma_state_t state_q, state_d;
    logic       parity_q, parity_d;
    logic [7:0] page_q, page_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;

    logic                     trigger;
    logic                     mem_req;
    logic                     mem_we;
    logic [MEM_ADDR_SIZE-1:0] mem_addr;
    logic [7:0]               mem_wdata;
    logic                     cpu_gnt;
    logic [7:0]               cpu_rdata;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its _d regardless of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            page_q   <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            page_q   <= page_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
        end
    end

    assign trigger = (state_q == IDLE) && bus.cpu_req_i && bus.cpu_we_i &&
                     (bus.cpu_addr_i == DMA_TRIG_ADDR);

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        state_d   = state_q;
        parity_d  = ~parity_q;
        page_d    = page_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_gnt   = 1'b0;
        cpu_rdata = '0;

        unique case (state_q)
            IDLE: begin
                mem_req   = bus.cpu_req_i;
                mem_we    = bus.cpu_we_i;
                mem_addr  = bus.cpu_addr_i;
                mem_wdata = bus.cpu_wdata_i;
                cpu_gnt   = bus.cpu_req_i && bus.mem_valid_i;
                cpu_rdata = bus.mem_rdata_i;
                // The trigger write is swallowed here and never reaches memory.
                if (trigger) begin
                    mem_req = 1'b0;
                    cpu_gnt = 1'b1;
                    page_d  = bus.cpu_wdata_i;
                    cnt_d   = '0;
                    state_d = HALT;
                end
            end
            HALT:  state_d = parity_q ? ALIGN : READ;
            ALIGN: state_d = READ;
            READ: begin
                mem_req  = 1'b1;
                mem_addr = {page_q, cnt_q};
                if (bus.mem_valid_i) begin
                    data_d  = bus.mem_rdata_i;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = OAM_DATA_ADDR;
                mem_wdata = data_q;
                if (bus.mem_valid_i) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = (cnt_q == 8'hFF) ? IDLE : READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dma_active_o    = (state_q != IDLE);
    assign bus.cpu_stall_o = dma_active_o;
    assign bus.cpu_gnt_o   = cpu_gnt;
    assign bus.cpu_rdata_o = cpu_rdata;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;

endmodule : oam_dma_arbiter

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: stimulus queues expected bus beats,
// CPU grants and stall lengths; a negedge monitor pops and compares them.
module tb_oam_dma_arbiter;
    import oam_dma_arbiter_pkg::*;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_exp_t;

    typedef struct {
        logic       is_read;
        logic [7:0] rdata;
    } cpu_exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic dma_active;

    oam_dma_arbiter_if bus ();

    oam_dma_arbiter dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .bus          (bus.slave),
        .dma_active_o (dma_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bus_exp_t bus_q[$];
    cpu_exp_t cpu_q[$];
    int       stall_q[$];

    int  cyc = 0;
    int  rd_seen = 0;
    int  wr_seen = 0;
    int  ws_rd = 0;
    int  ws_wr = 0;
    int  stall_len = 0;
    int  act_len = 0;
    logic       wait_en = 1'b0;
    logic       force_invalid = 1'b0;
    logic       use_fixed = 1'b0;
    logic [7:0] fixed_rdata = 8'h00;

    // Memory model: returns the low address byte unless a fixed value is set.
    assign bus.mem_rdata_i = use_fixed ? fixed_rdata : bus.mem_addr_o[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Clock-parity tracker: parity_q in a cycle equals posedges since reset, mod 2.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Bus completion driver, evaluated after the cycle's stimulus has settled.
    always @(posedge clk) begin
        #2;
        if (force_invalid) begin
            bus.mem_valid_i = 1'b0;
        end else if (wait_en && bus.mem_req_o && !bus.mem_we_o && rd_seen == 0 && ws_rd < 3) begin
            bus.mem_valid_i = 1'b0;
            ws_rd++;
        end else if (wait_en && bus.mem_req_o && bus.mem_we_o && wr_seen == 255 && ws_wr < 2) begin
            bus.mem_valid_i = 1'b0;
            ws_wr++;
        end else begin
            bus.mem_valid_i = 1'b1;
        end
    end

    // Monitor
    bus_exp_t be;
    cpu_exp_t ce;
    int       exp_len;
    always @(negedge clk) begin
        if (!rstn) begin
            stall_len = 0;
            act_len   = 0;
        end else begin
            if (bus.mem_req_o) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", {16'h0, bus.mem_addr_o}, 32'hFFFF_FFFF);
                end else begin
                    be = bus_q[0];
                    check("bus_we", {31'h0, bus.mem_we_o}, {31'h0, be.we});
                    check("bus_addr", {16'h0, bus.mem_addr_o}, {16'h0, be.addr});
                    if (be.we) check("bus_wdata", {24'h0, bus.mem_wdata_o}, {24'h0, be.data});
                    if (bus.mem_valid_i) begin
                        void'(bus_q.pop_front());
                        if (be.we) wr_seen++;
                        else       rd_seen++;
                    end
                end
            end
            if (bus.cpu_gnt_o) begin
                if (cpu_q.size() == 0) begin
                    check("gnt_unexpected", 32'h1, 32'h0);
                end else begin
                    ce = cpu_q.pop_front();
                    if (ce.is_read) check("cpu_rdata", {24'h0, bus.cpu_rdata_o}, {24'h0, ce.rdata});
                end
            end
            if (bus.cpu_stall_o) begin
                check("stall_gnt", {31'h0, bus.cpu_gnt_o}, 32'h0);
                check("stall_rdata", {24'h0, bus.cpu_rdata_o}, 32'h0);
            end
            if (bus.cpu_stall_o) stall_len++;
            if (dma_active)      act_len++;
            if (!bus.cpu_stall_o && !dma_active && (stall_len != 0 || act_len != 0)) begin
                if (stall_q.size() != 0) begin
                    exp_len = stall_q.pop_front();
                    check("stall_len", stall_len, exp_len);
                    check("active_len", act_len, exp_len);
                end
                stall_len = 0;
                act_len   = 0;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [15:0] addr,
                             input logic [7:0] wdata);
        bus.cpu_req_i   = req;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
    endtask

    // Issues a trigger in a cycle whose following (HALT) cycle has parity 'align'.
    task automatic do_trigger(input logic [7:0] page, input int align, input int extra);
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (((cyc + 1) & 1) == align) break;
        end
        rd_seen = 0;
        wr_seen = 0;
        ws_rd   = 0;
        ws_wr   = 0;
        for (int i = 0; i < 256; i++) begin
            bus_q.push_back('{we: 1'b0, addr: {page, 8'(i)}, data: 8'h00});
            bus_q.push_back('{we: 1'b1, addr: OAM_DATA_ADDR, data: 8'(i)});
        end
        stall_q.push_back(513 + align + extra);
        cpu_q.push_back('{is_read: 1'b0, rdata: 8'h00});
        cpu_drive(1'b1, 1'b1, DMA_TRIG_ADDR, page);
        cycle();
        cpu_drive(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    // Returns at the first negedge with the stall low; a timeout is a failure.
    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!bus.cpu_stall_o) done = 1'b1;
        end
        if (!done) check("stall_timeout", 32'h1, 32'h0);
    endtask

    task automatic cpu_read(input logic [15:0] addr, input logic [7:0] rdata);
        use_fixed   = 1'b1;
        fixed_rdata = rdata;
        bus_q.push_back('{we: 1'b0, addr: addr, data: 8'h00});
        cpu_q.push_back('{is_read: 1'b1, rdata: rdata});
        cpu_drive(1'b1, 1'b0, addr, 8'h00);
        @(negedge clk);
        check("pt_stall", {31'h0, bus.cpu_stall_o}, 32'h0);
        check("pt_gnt", {31'h0, bus.cpu_gnt_o}, 32'h1);
        cycle();
        cpu_drive(1'b0, 1'b0, 16'h0000, 8'h00);
        use_fixed = 1'b0;
    endtask

    initial begin
        logic hit;
        cpu_drive(1'b0, 1'b0, 16'h0000, 8'h00);
        bus.mem_valid_i = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_stall", {31'h0, bus.cpu_stall_o}, 32'h0);
        check("rst_active", {31'h0, dma_active}, 32'h0);
        check("rst_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
        check("rst_gnt", {31'h0, bus.cpu_gnt_o}, 32'h0);
        check("rst_rdata", {24'h0, bus.cpu_rdata_o}, 32'h0);
        check("rst_addr", {16'h0, bus.mem_addr_o}, 32'h0);
        cycle();
        rstn = 1'b1;
        cycle();

        // Pass-through read, and a read of the trigger address
        cpu_read(16'h8000, 8'hA9);
        cpu_read(DMA_TRIG_ADDR, 8'h5A);
        @(negedge clk);
        check("trig_read_no_dma", {31'h0, bus.cpu_stall_o}, 32'h0);

        // DMA with even parity at HALT
        do_trigger(8'h02, 0, 0);
        wait_idle();
        cycle();

        // DMA with odd parity; trigger cycle sees mem_valid_i low
        force_invalid = 1'b1;
        do_trigger(8'h11, 1, 0);
        force_invalid = 1'b0;
        wait_idle();
        cycle();

        // Wait states: 3 on the first read, 2 on the last write
        wait_en = 1'b1;
        do_trigger(8'hC5, 0, 5);
        wait_idle();
        wait_en = 1'b0;
        cycle();

        // CPU request held through the DMA
        do_trigger(8'h02, 1, 0);
        cpu_drive(1'b1, 1'b0, 16'h8000, 8'h00);
        bus_q.push_back('{we: 1'b0, addr: 16'h8000, data: 8'h00});
        cpu_q.push_back('{is_read: 1'b1, rdata: 8'h00});
        wait_idle();
        check("held_req_gnt", {31'h0, bus.cpu_gnt_o}, 32'h1);
        cycle();
        cpu_drive(1'b0, 1'b0, 16'h0000, 8'h00);
        cycle();

        // Reset while the write of cnt 0x40 is on the bus
        do_trigger(8'h03, 0, 0);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge clk);
            #3;
            if (wr_seen == 64 && bus.mem_we_o) hit = 1'b1;
        end
        check("reset_point_reached", {31'h0, hit}, 32'h1);
        rstn = 1'b0;
        bus_q.delete();
        stall_q.delete();
        #1;
        check("midrst_stall", {31'h0, bus.cpu_stall_o}, 32'h0);
        check("midrst_active", {31'h0, dma_active}, 32'h0);
        check("midrst_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_stall", {31'h0, bus.cpu_stall_o}, 32'h0);
            check("rst_hold_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
        end
        cycle();
        rstn = 1'b1;
        cycle();
        cpu_read(16'h8000, 8'hA9);

        // Parity restarts from reset: odd-parity DMA after release
        do_trigger(8'h07, 1, 0);
        wait_idle();
        repeat (2) cycle();

        check("bus_q_drained", bus_q.size(), 32'h0);
        check("cpu_q_drained", cpu_q.size(), 32'h0);
        check("stall_q_drained", stall_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_oam_dma_arbiter
